// File: rtl/counter_pkg.sv
// Shared definitions for the modulo counter family: limit-mode constants
// and the next-value rule used by every counter core.
package counter_pkg;

  localparam int SAT_WRAP  = 0;
  localparam int SAT_HOLD  = 1;
  localparam int CNT_MAX_W = 32;

  typedef struct packed {
    logic [CNT_MAX_W-1:0] cnt;
    logic                 limit;
  } next_t;

  // limit is set when the step is attempted at the terminal value for the
  // current direction; the result always stays inside 0..max.
  function automatic next_t next_count(
    input logic [CNT_MAX_W-1:0] cnt,
    input logic                 up,
    input logic [CNT_MAX_W-1:0] max,
    input logic                 sat
  );
    next_t r;
    r.limit = up ? (cnt == max) : (cnt == '0);
    if (!r.limit) begin
      r.cnt = up ? (cnt + CNT_MAX_W'(1)) : (cnt - CNT_MAX_W'(1));
    end else if (sat) begin
      r.cnt = cnt;
    end else begin
      r.cnt = up ? '0 : max;
    end
    return r;
  endfunction

endpackage

// File: rtl/clk_en_prescaler.sv
// Enable prescaler: emits one tick per PRESCALE enabled cycles.
// The phase holds while en is low and restarts from zero on clr.
module clk_en_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  if (PRESCALE < 1) begin : g_bad_prescale
    $error("clk_en_prescaler: PRESCALE must be at least 1");
  end

  if (PRESCALE == 1) begin : g_bypass
    logic unused_bypass;
    assign unused_bypass = ^{clk, rst, clr};
    assign tick = en;
  end else begin : g_div
    localparam int              PW   = $clog2(PRESCALE);
    localparam logic [PW-1:0]   LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] pre_q;
    logic [PW-1:0] pre_d;

    always_comb begin
      pre_d = pre_q;
      if (clr) begin
        pre_d = '0;
      end else if (en) begin
        pre_d = (pre_q == LAST) ? '0 : (pre_q + PW'(1));
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        pre_q <= '0;
      end else begin
        pre_q <= pre_d;
      end
    end

    assign tick = en && (pre_q == LAST);
  end

endmodule

// File: rtl/updown_mod_counter.sv
// Parametrised up/down modulo counter with clear, clamped load, prescaled
// enable, wrap or saturate at the limits, terminal-count and overflow flags.
module updown_mod_counter
  import counter_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MAX      = 15,
  parameter int SAT      = SAT_WRAP,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             up,
  output logic [WIDTH-1:0] o_cnt,
  output logic             o_tc,
  output logic             o_ovf
);

  if (WIDTH < 1 || WIDTH > CNT_MAX_W) begin : g_bad_width
    $error("updown_mod_counter: WIDTH must be in 1..32");
  end
  if (MAX < 1 || longint'(MAX) > ((longint'(1) << WIDTH) - 1)) begin : g_bad_max
    $error("updown_mod_counter: MAX must be in 1..2**WIDTH-1");
  end
  if (PRESCALE < 1) begin : g_bad_prescale
    $error("updown_mod_counter: PRESCALE must be at least 1");
  end
  if (SAT != SAT_WRAP && SAT != SAT_HOLD) begin : g_bad_sat
    $error("updown_mod_counter: SAT must be 0 (wrap) or 1 (hold)");
  end

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);
  localparam logic             SAT_B = (SAT == SAT_HOLD);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;
  logic             ovf_q;
  logic             ovf_d;
  logic             tick;
  next_t            step_res;

  // clr and load both restart the prescale period.
  clk_en_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr | load),
    .en   (en),
    .tick (tick)
  );

  assign step_res = next_count(CNT_MAX_W'(cnt_q), up, CNT_MAX_W'(MAX_V), SAT_B);

  always_comb begin
    cnt_d = cnt_q;
    ovf_d = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = (load_val > MAX_V) ? MAX_V : load_val;
    end else if (tick) begin
      cnt_d = WIDTH'(step_res.cnt);
      ovf_d = step_res.limit;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign o_cnt = cnt_q;
  assign o_tc  = step_res.limit;
  assign o_ovf = ovf_q;

endmodule

// File: doc/updown_mod_counter.md
# updown_mod_counter

Parametrised up/down modulo counter: the general-purpose successor to the fixed 4-bit free-running wrap counter. Adds configurable width and terminal value, direction control, synchronous clear and load, a clock-enable prescaler, wrap or saturate mode, and terminal-count and overflow flags. Used wherever a divider, timer or event counter is needed.

## Interface
Parameters:
- WIDTH, 4: counter width in bits; must be at least 1.
- MAX, 15: terminal value. Count range is 0..MAX. Requires 1 ≤ MAX ≤ 2^WIDTH−1.
- SAT, 0: limit behaviour. 0 = wrap, 1 = saturate.
- PRESCALE, 1: number of enabled cycles per count step. Requires PRESCALE ≥ 1.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- clr  in  1  synchronous clear.
- load  in  1  synchronous load of load_val.
- load_val  in  WIDTH  value to load.
- en  in  1  count enable; gates the prescaler.
- up  in  1  direction. 1 = increment, 0 = decrement.
- o_cnt  out  WIDTH  current count (registered).
- o_tc  out  1  terminal count (combinational from o_cnt and up).
- o_ovf  out  1  registered one-cycle pulse after a step attempted at the limit.

## Operation
- Priority, highest first: rst > clr > load > step.
- rst (async): o_cnt=0, prescaler=0, o_ovf=0.
- clr: o_cnt←0, prescaler←0.
- load: o_cnt←min(load_val, MAX), prescaler←0.
- Prescaler counts enabled cycles 0..PRESCALE−1 and wraps.
  - A step occurs on an en cycle when prescaler==PRESCALE−1.
  - With PRESCALE=1, every en cycle is a step.
  - When en=0, the prescaler holds.
  - Changing up does not touch the prescaler.
- Step, up=1:
  - If cnt<MAX: cnt+1.
  - If cnt==MAX: SAT=0 gives 0; SAT=1 holds MAX.
- Step, up=0:
  - If cnt>0: cnt−1.
  - If cnt==0: SAT=0 gives MAX; SAT=1 holds 0.
- Counter arithmetic is WIDTH bits wide. The next value is always within 0..MAX; never rely on natural 2^WIDTH rollover.
- o_tc = (up && cnt==MAX) || (!up && cnt==0).
- o_ovf is set for the cycle following any step taken while o_tc=1, in either mode. It is cleared otherwise.
- clr or load in the same cycle as a would-be step: the step is discarded and o_ovf=0.

## Timing
- o_cnt changes on the clk edge at which the step, clr or load is sampled. Latency is 1 cycle from inputs to o_cnt.
- o_tc has zero latency relative to o_cnt and up. A mid-run direction flip updates o_tc in the same cycle.
- o_ovf asserts in the same cycle that o_cnt shows the wrapped or held value. It lasts exactly 1 cycle per limit step; back-to-back limit steps keep it high.
- rst asserted mid-count: outputs go to 0 immediately, without waiting for clk. After rst deasserts, the first edge with en=1 begins a fresh prescale period.
- With en held high and PRESCALE=P, a full period is (MAX+1)·P cycles in wrap mode.

## Structure
- Shared package `counter_pkg`:
  - SAT_WRAP=0 and SAT_HOLD=1 constants.
  - A function next_count(cnt, up, max, sat) returning the next value and a limit flag.
- One sub-module: `clk_en_prescaler`, parameter PRESCALE. Ports: clk, rst, clr (prescaler reset), en. Output: tick.
  - The counter core steps only on tick.
  - For PRESCALE=1, tick=en.
- Parameter legality is checked at elaboration (MAX range, PRESCALE≥1).

## Test plan
- Decade wrap (WIDTH=4, MAX=9, SAT=0, P=1), up=1, en=1 from reset: o_cnt runs 0..9 then 0. o_tc is high at 9. o_ovf pulses with o_cnt=0 at cycle 10.
- Down saturate (SAT=1): load 2, then up=0 for 4 steps gives 1, 0, 0, 0. o_ovf is high in the last 2 of those cycles. o_tc stays high at 0.
- Prescaler (P=3, MAX=9): en held high gives a step every 3rd cycle. en dropped for 5 cycles mid-period, then resumed: the remaining period resumes and is not restarted.
- Load clamp and priority:
  - load_val=13 with MAX=9 gives o_cnt=9.
  - clr and load together gives 0.
  - load together with a would-be step gives load_val and o_ovf=0.
- Async reset mid-count: assert rst between edges at o_cnt=7. o_cnt=0 and o_ovf=0 before the next edge. The prescaler restarts from 0.
- Direction flip at the limit: at o_cnt=9 with up=1 (o_tc=1), set up=0. o_tc drops in the same cycle, and the next step gives 8 with no o_ovf.
